// File: rtl/cr_kme_fifo_packer.sv
// Packs 64-bit framed beats into 263-bit KME stall-protocol FIFO entries and writes them only while stall is low.
// Optional idle-timeout flush of partial entries is enabled by defining CR_KME_PACKER_TIMEOUT_EN.
module cr_kme_fifo_packer #(
  parameter int unsigned DATA_SIZE       = 263,
  parameter int unsigned BEATS_PER_ENTRY = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] fifo_in,
  output logic                 fifo_in_valid,
  input  logic                 fifo_in_stall,
  output logic                 proto_err,
  output logic [15:0]          entry_cnt
);

  if (DATA_SIZE != 263 || BEATS_PER_ENTRY < 1 || BEATS_PER_ENTRY > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cr_kme_fifo_packer: unsupported parameter set");
  end

  localparam logic [2:0] BEATS_L = 3'(BEATS_PER_ENTRY);

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_FILL,
    ACC_FULL
  } acc_state_t;

  acc_state_t           acc_state, acc_state_n;
  logic [255:0]         acc_data,  acc_data_n;
  logic [2:0]           acc_cnt,   acc_cnt_n;
  logic                 acc_sop,   acc_sop_n;
  logic                 acc_eop,   acc_eop_n;
  logic                 acc_in_pkt, acc_in_pkt_n;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_pend;
  logic                 proto_err_q;
  logic [15:0]          entry_cnt_q;

  logic                 push, out_free, accept, xfer, tmo_hit;
  logic [DATA_SIZE-1:0] xfer_entry;
  logic [255:0]         base_data, beat_slot, new_data;
  logic [2:0]           base_cnt, new_cnt;
  logic                 base_sop, new_sop, held_full, done;

  function automatic logic [DATA_SIZE-1:0] pack_entry(input logic [255:0] d, input logic [2:0] c,
                                                      input logic s, input logic e);
    return DATA_SIZE'({s, e, 3'b000, 2'(c - 3'd1), d});
  endfunction

  assign push          = out_pend & ~fifo_in_stall;
  assign fifo_in_valid = push;
  assign fifo_in       = out_data;
  assign out_free      = ~out_pend | push;
  // A FULL accumulator always transfers when the output register frees, so
  // readiness follows out_free alone and never looks at in_valid.
  assign in_ready      = (acc_state != ACC_FULL) | out_free;
  assign accept        = in_valid & in_ready;
  assign proto_err     = proto_err_q;
  assign entry_cnt     = entry_cnt_q;

`ifdef CR_KME_PACKER_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (acc_state == ACC_FILL) && !accept && (tmo_cnt >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (accept || acc_state != ACC_FILL) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Base is the accumulator as seen by an incoming beat: empty if the held
  // FULL entry leaves for the output register this same cycle.
  always_comb begin
    held_full = (acc_state == ACC_FULL);
    base_cnt  = held_full ? 3'd0 : acc_cnt;
    base_data = held_full ? '0 : acc_data;
    base_sop  = held_full ? 1'b0 : acc_sop;
    beat_slot = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (base_cnt == 3'(k)) beat_slot[64*k +: 64] = in_data;
    end
    new_data = base_data | beat_slot;
    new_cnt  = base_cnt + 3'd1;
    new_sop  = (base_cnt == 3'd0) ? in_sop : base_sop;
    done     = in_eop | (new_cnt == BEATS_L);
  end

  always_comb begin
    acc_state_n  = acc_state;
    acc_data_n   = acc_data;
    acc_cnt_n    = acc_cnt;
    acc_sop_n    = acc_sop;
    acc_eop_n    = acc_eop;
    acc_in_pkt_n = acc_in_pkt;
    xfer         = 1'b0;
    xfer_entry   = pack_entry(acc_data, acc_cnt, acc_sop, acc_eop);

    if (held_full && out_free) begin
      xfer        = 1'b1;
      acc_state_n = ACC_IDLE;
      acc_data_n  = '0;
      acc_cnt_n   = '0;
      acc_sop_n   = 1'b0;
      acc_eop_n   = 1'b0;
    end

    if (accept) begin
      acc_in_pkt_n = ~in_eop;
      if (done && !held_full && out_free) begin
        xfer        = 1'b1;
        xfer_entry  = pack_entry(new_data, new_cnt, new_sop, in_eop);
        acc_state_n = ACC_IDLE;
        acc_data_n  = '0;
        acc_cnt_n   = '0;
        acc_sop_n   = 1'b0;
        acc_eop_n   = 1'b0;
      end else begin
        acc_state_n = done ? ACC_FULL : ACC_FILL;
        acc_data_n  = new_data;
        acc_cnt_n   = new_cnt;
        acc_sop_n   = new_sop;
        acc_eop_n   = in_eop;
      end
    end else if (tmo_hit) begin
      if (out_free) begin
        xfer        = 1'b1;
        xfer_entry  = pack_entry(acc_data, acc_cnt, acc_sop, 1'b0);
        acc_state_n = ACC_IDLE;
        acc_data_n  = '0;
        acc_cnt_n   = '0;
        acc_sop_n   = 1'b0;
        acc_eop_n   = 1'b0;
      end else begin
        acc_state_n = ACC_FULL;
        acc_eop_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state   <= ACC_IDLE;
      acc_data    <= '0;
      acc_cnt     <= '0;
      acc_sop     <= 1'b0;
      acc_eop     <= 1'b0;
      acc_in_pkt  <= 1'b0;
      out_data    <= '0;
      out_pend    <= 1'b0;
      proto_err_q <= 1'b0;
      entry_cnt_q <= '0;
    end else begin
      acc_state  <= acc_state_n;
      acc_data   <= acc_data_n;
      acc_cnt    <= acc_cnt_n;
      acc_sop    <= acc_sop_n;
      acc_eop    <= acc_eop_n;
      acc_in_pkt <= acc_in_pkt_n;
      if (xfer) out_data <= xfer_entry;
      out_pend <= xfer | (out_pend & ~push);
      if (accept && (in_sop == acc_in_pkt)) proto_err_q <= 1'b1;
      if (push) entry_cnt_q <= entry_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_packer.sv
// Scoreboard bench for cr_kme_fifo_packer: stimulus queues expected entries, a negedge monitor checks every push.
module tb_cr_kme_fifo_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  in_data;
  logic         in_valid, in_sop, in_eop, in_ready;
  logic [262:0] fifo_in;
  logic         fifo_in_valid, fifo_in_stall, proto_err;
  logic [15:0]  entry_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ready_waits = 0;
  logic [262:0] exp_q[$];

  cr_kme_fifo_packer #(.DATA_SIZE(263), .BEATS_PER_ENTRY(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall), .proto_err(proto_err), .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [262:0] mk(input logic [255:0] d, input int unsigned cnt,
                                      input logic s, input logic e);
    logic [1:0] c = 2'(cnt - 1);
    return {s, e, 3'b000, c, d};
  endfunction

  task automatic chk(input string name, input logic [262:0] act, input logic [262:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic s, input logic e);
    int unsigned waits = 0;
    in_data = d; in_valid = 1'b1; in_sop = s; in_eop = e;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      ready_waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for beat %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt4(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
    exp_q.push_back(mk({b3, b2, b1, b0}, 4, 1'b1, 1'b1));
    send_beat(b0, 1'b1, 1'b0);
    send_beat(b1, 1'b0, 1'b0);
    send_beat(b2, 1'b0, 1'b0);
    send_beat(b3, 1'b0, 1'b1);
  endtask

  // Monitor: every push must be expected, in order, and never under stall.
  always @(negedge clk) begin
    if (rst_n && fifo_in_valid) begin
      checks++;
      if (fifo_in_stall) begin
        errors++;
        $display("FAIL push_under_stall: fifo_in_valid=1 while stall=1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got %h expected no push", fifo_in);
      end else begin
        logic [262:0] e;
        e = exp_q.pop_front();
        if (fifo_in !== e) begin
          errors++;
          $display("FAIL entry: got %h expected %h", fifo_in, e);
        end
      end
    end
  end

  initial begin
    int unsigned stalled_pushes;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    fifo_in_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 263'(in_ready), 263'(1));
    chk("reset_valid", 263'(fifo_in_valid), 263'(0));
    chk("reset_fifo_in", fifo_in, '0);
    chk("reset_proto_err", 263'(proto_err), 263'(0));
    chk("reset_entry_cnt", 263'(entry_cnt), 263'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 4-beat packet, one-cycle latency to the write strobe.
    send_pkt4(64'h11, 64'h22, 64'h33, 64'h44);
    chk("latency_valid", 263'(fifo_in_valid), 263'(1));
    repeat (2) @(posedge clk); #1;
    chk("entry_cnt_1", 263'(entry_cnt), 263'(1));

    // 6-beat packet splits into two entries.
    exp_q.push_back(mk({64'h104, 64'h103, 64'h102, 64'h101}, 4, 1'b1, 1'b0));
    exp_q.push_back(mk({64'h0, 64'h0, 64'h106, 64'h105}, 2, 1'b0, 1'b1));
    send_beat(64'h101, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) send_beat(64'(256 + i), 1'b0, 1'b0);
    send_beat(64'h106, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("entry_cnt_3", 263'(entry_cnt), 263'(3));

    // Stall: one pending entry plus one full accumulator, then in_ready drops.
    fifo_in_stall = 1'b1;
    exp_q.push_back(mk({192'h0, 64'hAA}, 1, 1'b1, 1'b1));
    send_beat(64'hAA, 1'b1, 1'b1);
    send_pkt4(64'hB1, 64'hB2, 64'hB3, 64'hB4);
    chk("stall_in_ready_low", 263'(in_ready), 263'(0));
    stalled_pushes = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_in_valid) stalled_pushes++;
    end
    chk("stall_no_push", 263'(stalled_pushes), 263'(0));
    @(posedge clk); #1;
    fifo_in_stall = 1'b0;
    @(negedge clk);
    chk("unstall_push", 263'(fifo_in_valid), 263'(1));
    repeat (3) @(posedge clk); #1;
    chk("entry_cnt_5", 263'(entry_cnt), 263'(5));

    // Back-to-back packets: in_ready never drops, nothing lost.
    ready_waits = 0;
    send_pkt4(64'hC01, 64'hC02, 64'hC03, 64'hC04);
    send_pkt4(64'hC11, 64'hC12, 64'hC13, 64'hC14);
    send_pkt4(64'hC21, 64'hC22, 64'hC23, 64'hC24);
    chk("b2b_ready_waits", 263'(ready_waits), 263'(0));
    repeat (2) @(posedge clk); #1;
    chk("entry_cnt_8", 263'(entry_cnt), 263'(8));

    // sop inside an open packet: flagged, sticky, beat still packed.
    chk("proto_err_clean", 263'(proto_err), 263'(0));
    exp_q.push_back(mk({64'hD4, 64'hD3, 64'hD2, 64'hD1}, 4, 1'b1, 1'b1));
    send_beat(64'hD1, 1'b1, 1'b0);
    send_beat(64'hD2, 1'b1, 1'b0);
    send_beat(64'hD3, 1'b0, 1'b0);
    send_beat(64'hD4, 1'b0, 1'b1);
    chk("proto_err_set", 263'(proto_err), 263'(1));
    send_pkt4(64'hE1, 64'hE2, 64'hE3, 64'hE4);
    repeat (2) @(posedge clk); #1;
    chk("proto_err_sticky", 263'(proto_err), 263'(1));
    chk("entry_cnt_10", 263'(entry_cnt), 263'(10));
    chk("queue_drained", 263'(exp_q.size()), 263'(0));

    // Reset with a pending entry and a partial entry: both discarded.
    fifo_in_stall = 1'b1;
    send_beat(64'hF0, 1'b1, 1'b1);
    send_beat(64'hF1, 1'b1, 1'b0);
    send_beat(64'hF2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    fifo_in_stall = 1'b0;
    chk("midrst_valid", 263'(fifo_in_valid), 263'(0));
    chk("midrst_fifo_in", fifo_in, '0);
    chk("midrst_entry_cnt", 263'(entry_cnt), 263'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("midrst_in_ready", 263'(in_ready), 263'(1));
    chk("midrst_proto_err", 263'(proto_err), 263'(0));
    chk("midrst_no_push", 263'(entry_cnt), 263'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
